hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1: bubble cycles per load-use hazard in counter mode; legal range 1..7.
REQ-002 Parameter USE_MEM_RESP, default 0: 0 selects counter mode; 1 holds the stall until mem_resp.
REQ-003 Parameter CNT_W, default 16: width of the stall event counter.
REQ-004 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-005 Reset is synchronous and active-low: reset_n  in  1.
REQ-006 instruction_curr  in  16  decode-stage instruction (consumer).
REQ-007 instruction_last  in  16  execute-stage instruction (producer).
REQ-008 flushed  in  1  execute-stage instruction is squashed; it is not a valid producer.
REQ-009 mem_resp  in  1  data-memory response for the in-flight load; used only when USE_MEM_RESP=1.
REQ-010 stall_pipeline_load  out  1  freeze fetch/decode and inject a bubble into execute.
REQ-011 hazard_src  out  3  registered operand match of the last detected hazard: bit0 SR1[8:6], bit1 SR2[2:0], bit2 store source[11:9].
REQ-012 stall_remaining  out  3  cycles left in the current stall (counter mode); 0 otherwise.
REQ-013 stall_event_count  out  CNT_W  saturating count of detected hazards.

Function
REQ-014 Producer: instruction_last[15:12] is LDB 0010, LDR 0110 or LDI 1010, and flushed=0; DR = instruction_last[11:9].
REQ-015 SR1 read by ADD 0001, AND 0101, NOT 1001, LDB, STB 0011, LDR, STR 0111, JMP 1100, SHF 1101, and JSRR (0100 with bit11=0).
REQ-016 SR2 read only by ADD/AND with bit5=0; store source [11:9] read by STB, STR, STI 1011.
REQ-017 BR, JSR (bit11=1), LEA, TRAP, RTI and LDI consumers never match SR1.
REQ-018 hazard = producer AND any enabled operand field equals DR; match vector as in REQ-011.
REQ-019 States: S_CHECK, S_STALL, S_RELEASE; the reset state is S_CHECK.
REQ-020 S_CHECK: stall_pipeline_load = hazard, combinational, in the same cycle.
REQ-021 S_CHECK, no hazard: remain in S_CHECK.
REQ-022 S_CHECK, hazard, counter mode, LOAD_STALL_CYCLES=1: go to S_RELEASE.
REQ-023 S_CHECK, hazard, counter mode, LOAD_STALL_CYCLES>1: go to S_STALL and load stall_remaining = LOAD_STALL_CYCLES-1.
REQ-024 S_CHECK, hazard, mem-resp mode: go to S_STALL.
REQ-025 On hazard in S_CHECK: hazard_src latches the match vector and stall_event_count increments, saturating at all-ones.
REQ-026 S_STALL, counter mode: stall=1; decrement stall_remaining each cycle; when the value is 1, go to S_RELEASE (stall_remaining becomes 0).
REQ-027 S_STALL, mem-resp mode: stall = !mem_resp; when mem_resp=1 go directly to S_RELEASE.
REQ-028 S_STALL, flushed=1: stall=0 that cycle, clear stall_remaining, go to S_CHECK; flushed takes priority over mem_resp.
REQ-029 S_RELEASE: stall=0, no detection, unconditionally return to S_CHECK.
REQ-030 Total stall in counter mode is exactly LOAD_STALL_CYCLES consecutive cycles.
REQ-031 mem_resp arriving in S_CHECK or S_RELEASE is ignored.
REQ-032 Back-to-back loads: a second hazard is detected only once S_CHECK is re-entered.

Reset
REQ-033 When reset_n=0 at a rising edge, the next state is S_CHECK and stall_remaining=0, hazard_src=0, stall_event_count=0.
REQ-034 While reset_n=0, stall_pipeline_load=0 regardless of the inputs.
REQ-035 Reset asserted mid-stall aborts the stall within one cycle.

Verification
REQ-036 Defaults: last=LDR R2 (0x6480), curr=ADD R3,R2,#1 (0x16A1) -> stall=1 for one cycle, next cycle 0, hazard_src=001, count=1.
REQ-037 LOAD_STALL_CYCLES=3: last=LDB R1, curr=ADD R4,R5,R1 (bit5=0) -> stall for 3 cycles, stall_remaining 2,1,0, hazard_src=010.
REQ-038 last=LDR R1, curr=STR R1,R6,#0 -> hazard_src=100 and stall asserted. Same producer with curr=BR or LEA R1 -> no stall.
REQ-039 USE_MEM_RESP=1: hazard, mem_resp low for 4 cycles then high -> stall for 5 cycles. The mem_resp cycle has stall=0, then S_RELEASE, then S_CHECK.
REQ-040 Hazard with flushed=1 -> no stall. LOAD_STALL_CYCLES=4 with flushed pulsed during the 2nd stall cycle -> stall drops that cycle, state returns to S_CHECK.
REQ-041 CNT_W=2: drive 5 hazards -> stall_event_count saturates at 3. reset_n low mid-stall -> stall=0 and all outputs 0 after the edge.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Load-use hazard detector and stall sequencer for a 16-bit LC-3b style
//   pipeline. A load in execute (LDB/LDR/LDI, not squashed) whose destination
//   register is read by the instruction in decode freezes fetch/decode and
//   injects a bubble into execute. The bubble ends after a fixed number of
//   cycles (counter mode) or when the data memory responds (mem-resp mode).
//
// Parameters
//   LOAD_STALL_CYCLES  bubble cycles per hazard in counter mode (1..7)
//   USE_MEM_RESP       0: counter mode, 1: hold stall until mem_resp
//   CNT_W              width of the saturating hazard event counter
//
// Ports
//   clk                  in   pipeline clock, rising edge
//   reset_n              in   synchronous active-low reset
//   instruction_curr     in   [15:0] decode-stage instruction (consumer)
//   instruction_last     in   [15:0] execute-stage instruction (producer)
//   flushed              in   execute-stage instruction is squashed
//   mem_resp             in   data-memory response (mem-resp mode only)
//   stall_pipeline_load  out  freeze fetch/decode, bubble into execute
//   hazard_src           out  [2:0] latched match: {store src, SR2, SR1}
//   stall_remaining      out  [2:0] cycles left in current stall (counter mode)
//   stall_event_count    out  [CNT_W-1:0] saturating count of hazards
module hazard_stall_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned USE_MEM_RESP      = 0,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      instruction_curr,
  input  logic [15:0]      instruction_last,
  input  logic             flushed,
  input  logic             mem_resp,
  output logic             stall_pipeline_load,
  output logic [2:0]       hazard_src,
  output logic [2:0]       stall_remaining,
  output logic [CNT_W-1:0] stall_event_count
);

  typedef enum logic [1:0] {
    S_CHECK   = 2'd0,
    S_STALL   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [2:0] rem_next;
  logic       stall_c;

  logic [3:0] op_curr, op_last;
  logic [2:0] dr;
  logic       producer;
  logic       use_sr1, use_sr2, use_st;
  logic [2:0] match;
  logic       hazard;

  // Instruction bits that never take part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^{instruction_curr[4:3], instruction_last[8:0]};

  assign op_curr = instruction_curr[15:12];
  assign op_last = instruction_last[15:12];
  assign dr      = instruction_last[11:9];

  // Producer: LDB / LDR / LDI that has not been squashed.
  always_comb begin
    producer = 1'b0;
    case (op_last)
      4'b0010, 4'b0110, 4'b1010: producer = !flushed;
      default:                   producer = 1'b0;
    endcase
  end

  // Operand-field enables of the consumer.
  always_comb begin
    use_sr1 = 1'b0;
    use_sr2 = 1'b0;
    use_st  = 1'b0;
    case (op_curr)
      4'b0001, 4'b0101: begin            // ADD, AND
        use_sr1 = 1'b1;
        use_sr2 = !instruction_curr[5];
      end
      4'b1001, 4'b0010, 4'b0110,
      4'b1100, 4'b1101: use_sr1 = 1'b1; // NOT, LDB, LDR, JMP, SHF
      4'b0011, 4'b0111: begin            // STB, STR
        use_sr1 = 1'b1;
        use_st  = 1'b1;
      end
      4'b1011: use_st = 1'b1;            // STI
      4'b0100: use_sr1 = !instruction_curr[11]; // JSRR only
      default: begin
        use_sr1 = 1'b0;
        use_sr2 = 1'b0;
        use_st  = 1'b0;
      end
    endcase
  end

  assign match[0] = use_sr1 && (instruction_curr[8:6]  == dr);
  assign match[1] = use_sr2 && (instruction_curr[2:0]  == dr);
  assign match[2] = use_st  && (instruction_curr[11:9] == dr);
  assign hazard   = producer && (match != 3'b000);

  // Next-state and stall decode.
  always_comb begin
    state_next = state;
    rem_next   = stall_remaining;
    stall_c    = 1'b0;
    case (state)
      S_CHECK: begin
        stall_c = hazard;
        if (hazard) begin
          if (USE_MEM_RESP != 0) begin
            state_next = S_STALL;
          end else if (LOAD_STALL_CYCLES <= 1) begin
            state_next = S_RELEASE;
          end else begin
            state_next = S_STALL;
            rem_next   = 3'(LOAD_STALL_CYCLES - 1);
          end
        end
      end
      S_STALL: begin
        if (flushed) begin
          // Squashed producer: the bubble is pointless, drop it now.
          stall_c    = 1'b0;
          rem_next   = '0;
          state_next = S_CHECK;
        end else if (USE_MEM_RESP != 0) begin
          stall_c = !mem_resp;
          if (mem_resp) state_next = S_RELEASE;
        end else begin
          stall_c = 1'b1;
          if (stall_remaining <= 3'd1) begin
            rem_next   = '0;
            state_next = S_RELEASE;
          end else begin
            rem_next = stall_remaining - 3'd1;
          end
        end
      end
      S_RELEASE: begin
        stall_c    = 1'b0;
        state_next = S_CHECK;
      end
      default: begin
        stall_c    = 1'b0;
        rem_next   = '0;
        state_next = S_CHECK;
      end
    endcase
  end

  // Gated by reset so the pipeline is never frozen while held in reset.
  assign stall_pipeline_load = reset_n && stall_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= S_CHECK;
      stall_remaining   <= '0;
      hazard_src        <= '0;
      stall_event_count <= '0;
    end else begin
      state           <= state_next;
      stall_remaining <= rem_next;
      if (state == S_CHECK && hazard) begin
        hazard_src <= match;
        if (stall_event_count != '1)
          stall_event_count <= stall_event_count + CNT_W'(1);
      end
    end
  end

endmodule
